// File: rtl/seg_arb_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
// The counter-width helper sizes counters from module parameters.
package seg_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHOW,
    BLANK
  } seg_arb_state_t;

  localparam int NIBBLE_W = 4;
  localparam int SLOT_W   = 16;

  localparam int HOLD_CYCLES_DEF  = 1000;
  localparam int BLANK_CYCLES_DEF = 4;

  // A counter must be able to hold the value n itself, because the hold count saturates there.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

  localparam int HOLD_CNT_W_DEF  = cnt_w(HOLD_CYCLES_DEF);
  localparam int BLANK_CNT_W_DEF = cnt_w(BLANK_CYCLES_DEF);

endpackage

// File: rtl/seg_rr_pick.sv
// Combinational round-robin picker: the first set req bit found after 'last',
// searching upwards and wrapping around.
module seg_rr_pick
  import seg_arb_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic             hit,
  output logic [IDX_W-1:0] idx
);

  // Walk the candidates from farthest to nearest so the nearest hit is written last.
  always_comb begin
    int cand;
    hit  = 1'b0;
    idx  = '0;
    cand = 0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = (int'(last) + k) % N_REQ;
      if (req[cand]) begin
        hit = 1'b1;
        idx = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/seg_disp_arbiter.sv
// Round-robin arbiter that shares a four-digit seven-segment display between
// requesters. It enforces a minimum hold window and a fixed blank gap.
module seg_disp_arbiter
  import seg_arb_pkg::*;
#(
  parameter int N_REQ        = 3,
  parameter int HOLD_CYCLES  = HOLD_CYCLES_DEF,
  parameter int BLANK_CYCLES = BLANK_CYCLES_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  input  logic [SLOT_W*N_REQ-1:0]    data_in,
  output logic [N_REQ-1:0]           grant,
  output logic [NIBBLE_W-1:0]        data3,
  output logic [NIBBLE_W-1:0]        data2,
  output logic [NIBBLE_W-1:0]        data1,
  output logic [NIBBLE_W-1:0]        data0,
  output logic                       disp_en,
  output logic                       busy
);

  localparam int IDX_W   = $clog2(N_REQ);
  localparam int HOLD_W  = cnt_w(HOLD_CYCLES);
  localparam int BLANK_W = cnt_w(BLANK_CYCLES);

  seg_arb_state_t      state_q;
  logic [N_REQ-1:0]    grant_q;
  logic [SLOT_W-1:0]   data_q;
  logic                disp_en_q;
  logic                busy_q;
  logic [HOLD_W-1:0]   hold_q;
  logic [BLANK_W-1:0]  blank_q;
  logic [IDX_W-1:0]    last_q;

  logic [SLOT_W-1:0]   slot [N_REQ];
  logic                pick_hit;
  logic [IDX_W-1:0]    pick_idx;
  logic                owner_req;
  logic                other_req;
  logic                hold_done;
  logic                blank_last;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slot
    assign slot[gi] = data_in[SLOT_W*gi +: SLOT_W];
  end

  seg_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req  (req),
    .last (last_q),
    .hit  (pick_hit),
    .idx  (pick_idx)
  );

  assign owner_req  = |(req & grant_q);
  assign other_req  = |(req & ~grant_q);
  assign hold_done  = hold_q >= HOLD_W'(HOLD_CYCLES - 1);
  assign blank_last = blank_q == BLANK_W'(BLANK_CYCLES - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      data_q    <= '0;
      disp_en_q <= 1'b0;
      busy_q    <= 1'b0;
      hold_q    <= '0;
      blank_q   <= '0;
      last_q    <= IDX_W'(N_REQ - 1);
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_hit) begin
            state_q   <= SHOW;
            grant_q   <= N_REQ'(1) << pick_idx;
            last_q    <= pick_idx;
            data_q    <= slot[pick_idx];
            disp_en_q <= 1'b1;
            busy_q    <= 1'b1;
            hold_q    <= '0;
          end
        end

        SHOW: begin
          // An owner that drops its request leaves at once. A held owner yields only under contention.
          if (!owner_req || (hold_done && other_req)) begin
            state_q   <= BLANK;
            grant_q   <= '0;
            data_q    <= '0;
            disp_en_q <= 1'b0;
            blank_q   <= '0;
          end else begin
            data_q <= slot[last_q];
            if (hold_q != HOLD_W'(HOLD_CYCLES)) begin
              hold_q <= hold_q + 1'b1;
            end
          end
        end

        BLANK: begin
          if (blank_last) begin
            if (pick_hit) begin
              state_q   <= SHOW;
              grant_q   <= N_REQ'(1) << pick_idx;
              last_q    <= pick_idx;
              data_q    <= slot[pick_idx];
              disp_en_q <= 1'b1;
              hold_q    <= '0;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            blank_q <= blank_q + 1'b1;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign grant   = grant_q;
  assign data3   = data_q[15:12];
  assign data2   = data_q[11:8];
  assign data1   = data_q[7:4];
  assign data0   = data_q[3:0];
  assign disp_en = disp_en_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_seg_disp_arbiter.sv
// Directed bench for seg_disp_arbiter using N_REQ=3, HOLD_CYCLES=8 and BLANK_CYCLES=2.
// Expected values are hand-derived cycle by cycle.
module tb_seg_disp_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req;
  logic [15:0] s0, s1, s2;
  logic [47:0] data_in;
  logic [2:0]  grant;
  logic [3:0]  data3, data2, data1, data0;
  logic        disp_en;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  assign data_in = {s2, s1, s0};

  always #5 clk = ~clk;

  seg_disp_arbiter #(
    .N_REQ        (3),
    .HOLD_CYCLES  (8),
    .BLANK_CYCLES (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .data_in (data_in),
    .grant   (grant),
    .data3   (data3),
    .data2   (data2),
    .data1   (data1),
    .data0   (data0),
    .disp_en (disp_en),
    .busy    (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [2:0] g, input logic [15:0] d,
                            input logic de, input logic b);
    chk({tag, ".grant"},   32'(grant), 32'(g));
    chk({tag, ".data"},    32'({data3, data2, data1, data0}), 32'(d));
    chk({tag, ".disp_en"}, 32'(disp_en), 32'(de));
    chk({tag, ".busy"},    32'(busy), 32'(b));
  endtask

  task automatic show_run(input string tag, input logic [2:0] g, input logic [15:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      expect_out(tag, g, d, 1'b1, 1'b1);
    end
  endtask

  task automatic blank_run(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      expect_out(tag, 3'b000, 16'h0000, 1'b0, 1'b1);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 3'b000;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    req = 3'b111;
    s0  = 16'h1234;
    s1  = 16'hABCD;
    s2  = 16'h5678;

    // 1: reset holds everything at zero even with every request raised.
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out("rst_hold", 3'b000, 16'h0000, 1'b0, 1'b0);
    end
    rst = 1'b0;
    tick();
    expect_out("rst_first", 3'b001, 16'h1234, 1'b1, 1'b1);
    $display("[TB] scenario 1 reset done");

    // 2: contention between requesters 0 and 1.
    do_reset();
    req = 3'b011;
    show_run("rr_own0", 3'b001, 16'h1234, 8);
    blank_run("rr_gap0", 2);
    show_run("rr_own1", 3'b010, 16'hABCD, 8);
    blank_run("rr_gap1", 2);
    show_run("rr_own0b", 3'b001, 16'h1234, 1);
    $display("[TB] scenario 2 round robin done");

    // 3: a sole requester keeps the display and its live updates show through.
    do_reset();
    req = 3'b100;
    show_run("sole_a", 3'b100, 16'h5678, 25);
    s2 = 16'h0042;
    show_run("sole_b", 3'b100, 16'h0042, 25);
    $display("[TB] scenario 3 sole requester done");

    // 4: the owner drops its request in SHOW cycle 3 while requester 2 rises.
    do_reset();
    req = 3'b001;
    show_run("drop_own", 3'b001, 16'h1234, 3);
    req = 3'b100;
    blank_run("drop_gap", 2);
    show_run("drop_next", 3'b100, 16'h0042, 1);
    $display("[TB] scenario 4 early drop done");

    // 5: the search wraps from last=2 to index 0 and later returns to index 2.
    do_reset();
    req = 3'b100;
    show_run("wrap_own2", 3'b100, 16'h0042, 1);
    req = 3'b101;
    show_run("wrap_own2h", 3'b100, 16'h0042, 7);
    blank_run("wrap_gap0", 2);
    show_run("wrap_own0", 3'b001, 16'h1234, 8);
    blank_run("wrap_gap1", 2);
    show_run("wrap_back2", 3'b100, 16'h0042, 1);
    $display("[TB] scenario 5 wrap-around done");

    // 6: a reset pulse during SHOW restarts the search pointer.
    do_reset();
    req = 3'b110;
    show_run("mid_own1", 3'b010, 16'hABCD, 2);
    rst = 1'b1;
    tick();
    expect_out("mid_rst", 3'b000, 16'h0000, 1'b0, 1'b0);
    rst = 1'b0;
    show_run("mid_after", 3'b010, 16'hABCD, 1);
    $display("[TB] scenario 6 mid-show reset done");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_disp_arbiter.md
# seg_disp_arbiter

Round-robin arbiter that shares the four-digit `seven_seg_display` between up to `N_REQ` requesters, such as an ALU result, a register viewer and a PC monitor. Each requester raises a level request and presents a 16-bit (4-nibble) value. The arbiter grants one requester at a time for a guaranteed minimum hold window and inserts a blank gap between owners. It drives `data3..data0` and an enable to the display driver.

## Interface
Parameters:
- `N_REQ`, default 3: number of requesters, 2..8.
- `HOLD_CYCLES`, default 1000: minimum SHOW cycles per grant before preemption is allowed, ≥1.
- `BLANK_CYCLES`, default 4: exact length of the gap between owners, ≥1.

Ports:
- `clk` in 1: single clock, all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset; overrides all other inputs.
- `req` in N_REQ: level request; bit i belongs to requester i.
- `data_in` in 16*N_REQ: requester i occupies [16i+15:16i].
- `grant` out N_REQ: one-hot or zero; registered.
- `data3`, `data2`, `data1`, `data0` out 4 each: nibbles [15:12], [11:8], [7:4], [3:0] of the granted slot; registered.
- `disp_en` out 1: 1 only in SHOW.
- `busy` out 1: 1 in SHOW or BLANK.

## Operation
- States: IDLE, SHOW, BLANK.
- Reset values: state IDLE, `grant`=0, all data outputs=0, `disp_en`=0, `busy`=0, hold counter 0, blank counter 0, last-owner pointer `last`=N_REQ-1.
- Priority search: start at (`last`+1) mod N_REQ, wrap around, and take the first set `req` bit. Immediately after reset this gives index 0 priority.
- IDLE, any `req` bit set: the winner is w. Next cycle: SHOW, `grant`=one-hot(w), `last`=w, data outputs loaded from slot w.
- SHOW, every cycle:
  - Data outputs reload from the granted slot. Live updates from the owner are allowed.
  - The hold counter increments and saturates at HOLD_CYCLES.
- SHOW exits to BLANK on either condition, evaluated in the same cycle:
  - (a) The owner's `req` bit is 0. This applies regardless of the hold counter.
  - (b) The hold counter has reached HOLD_CYCLES-1 (i.e. this is the HOLD_CYCLES-th SHOW cycle) and any other `req` bit is 1.
- SHOW with neither condition true: stay in SHOW. A sole requester keeps the display indefinitely.
- On entering BLANK: `grant`=0, data outputs=0, `disp_en`=0, blank counter cleared.
- BLANK lasts exactly BLANK_CYCLES cycles. In the last BLANK cycle, the priority search runs on the current `req`:
  - A hit goes to SHOW as from IDLE.
  - No hit goes to IDLE.
  - A request that drops during BLANK is not considered.
  - The previous owner can win again only if no other requester is set.
- `req` bits that are set and dropped while the block is in SHOW for another owner are ignored. Nothing is latched.
- `rst` asserted mid-SHOW or mid-BLANK: the next cycle shows the full reset values, and `last` returns to N_REQ-1.

## Timing
- Request to grant latency: 1 cycle from IDLE (req sampled at edge t, `grant` visible after edge t).
- `data_in` change to data output: 1 cycle while granted.
- Owner drops `req` at cycle t: `grant`=0 and `disp_en`=0 after edge t. The next owner's grant appears BLANK_CYCLES cycles later.
- Contended handover: owner holds for exactly HOLD_CYCLES cycles, then BLANK_CYCLES blank cycles, then the next grant. Period per owner is HOLD_CYCLES+BLANK_CYCLES.
- `grant` is never active in two consecutive cycles for different owners; at least BLANK_CYCLES zero cycles separate them.

## Structure
- Package `seg_arb_pkg`:
  - state enum `seg_arb_state_t` {IDLE, SHOW, BLANK};
  - `NIBBLE_W`=4;
  - `SLOT_W`=16;
  - `localparam` counter widths derived with $clog2 from HOLD_CYCLES and BLANK_CYCLES.
- Sub-module `seg_rr_pick`: combinational round-robin picker.
  - Inputs: `req`, `last`.
  - Outputs: `hit`, `idx`.
  - Instantiated once and reused by the IDLE and BLANK exits.
- Top level holds the FSM, both counters, `last`, and the output registers.

## Test plan
All scenarios use N_REQ=3, HOLD_CYCLES=8, BLANK_CYCLES=2.

1. Reset: `rst`=1 for 3 cycles with `req`=3'b111 → `grant`=0, data=0, `disp_en`=0, `busy`=0 throughout. First grant is 3'b001, one cycle after `rst` falls.
2. `req`=3'b011 held, slot0=16'h1234, slot1=16'hABCD → pattern repeats: `grant` 001 for 8 cycles showing 1,2,3,4; 2 zero cycles; `grant` 010 for 8 cycles showing A,B,C,D; 2 zero cycles.
3. Sole requester: `req`=3'b100 held for 50 cycles → `grant`=100 for all cycles after the first. No BLANK occurs. A change of slot2 to 16'h0042 is visible 1 cycle later.
4. Early drop: `req`=3'b001, owner drops at SHOW cycle 3 while `req[2]` rises → `grant`=0 next cycle, 2 blank cycles, then `grant`=100.
5. Wrap-around: `last`=2 and `req`=3'b101 at BLANK end → index 0 wins. A later handover goes to index 2.
6. `rst` pulsed mid-SHOW of owner 1 with `req`=3'b110 → reset values for the pulse. The first grant afterwards is index 1, because the search restarts at 0.
